operand_loader: RTL and testbench

Operand staging stage directly upstream of the matrix-multiply controller and ALU. It accepts 32-bit bus words over a valid/ready stream while the controller asserts `load_en`, packs one 8-element A segment and one 8-element B segment, and pulses `load_done`. It then presents one (A, B) element pair per `alu_en` cycle to the ALU.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/operand_loader_if.sv | 21 ++
 rtl/operand_shreg.sv | 40 ++++
 rtl/operand_loader.sv | 120 ++++++++++++
 tb/tb_operand_loader.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizing constants and loader state encoding
package matrix_pkg;

  localparam int DATA_W = 8;
  localparam int ELEMS  = 8;
  localparam int BUS_W  = 32;
  localparam int WORDS  = 2 * ELEMS * DATA_W / BUS_W;
  localparam int WPS    = WORDS / 2;
  localparam int EPW    = BUS_W / DATA_W;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int ECNT_W = $clog2(ELEMS + 1);
  localparam int IDX_W  = (WPS > 1) ? $clog2(WPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL,
    ST_DRAIN
  } load_state_e;

endpackage

// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - bus word input stream and ALU operand output bundle
interface operand_loader_if;

  logic                         in_valid;
  logic [matrix_pkg::BUS_W-1:0] in_data;
  logic                         in_ready;
  logic                         op_valid;
  logic [matrix_pkg::DATA_W-1:0] a_out;
  logic [matrix_pkg::DATA_W-1:0] b_out;

  modport master (
    output in_valid, in_data,
    input  in_ready, op_valid, a_out, b_out
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, op_valid, a_out, b_out
  );

endinterface

// File: rtl/operand_shreg.sv
// rtl/operand_shreg.sv - one operand segment: word-wide writes, element-wide head shift
module operand_shreg
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic              shift_en,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [ELEMS];
  logic [DATA_W-1:0] mem_d [ELEMS];

  always_comb begin
    mem_d = mem_q;
    if (shift_en) begin
      for (int i = 0; i < ELEMS - 1; i++) mem_d[i] = mem_q[i + 1];
      mem_d[ELEMS-1] = '0;
    end else if (wr_en) begin
      // Word w covers elements w*EPW .. w*EPW+EPW-1, lowest byte first.
      for (int i = 0; i < ELEMS; i++) begin
        if ((i / EPW) == int'(wr_idx)) mem_d[i] = wr_data[(i % EPW)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ELEMS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[0];

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - packs A/B operand segments from bus words, then feeds the ALU
module operand_loader
  import matrix_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            alu_en,
  operand_loader_if.slave bus,
  output logic            load_done,
  output logic            err
);

  load_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;
  logic              load_done_q, load_done_d;
  logic              err_q, err_d;
  logic              ready, accept, shift, op_valid, is_a;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] a_head, b_head;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ecnt_d      = ecnt_q;
    load_done_d = 1'b0;
    err_d       = err_q;
    ready       = 1'b0;
    shift       = 1'b0;
    op_valid    = 1'b0;
    if (load_en && alu_en) err_d = 1'b1;
    case (state_q)
      ST_IDLE: if (load_en && !alu_en) state_d = ST_FILL;
      ST_FILL: begin
        ready = load_en;
        if (alu_en) err_d = 1'b1;
        if (ready && bus.in_valid) begin
          if (wcnt_q == WCNT_W'(WORDS - 1)) begin
            wcnt_d      = '0;
            state_d     = ST_FULL;
            load_done_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_FULL, ST_DRAIN: begin
        if (alu_en) begin
          op_valid = 1'b1;
          shift    = 1'b1;
          if (state_q == ST_FULL) begin
            ecnt_d  = ECNT_W'(1);
            state_d = ST_DRAIN;
          end else if (ecnt_q == ECNT_W'(ELEMS - 1)) begin
            ecnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            ecnt_d = ecnt_q + 1'b1;
          end
        end else if (load_en) begin
          // Controller restarted a load over unread data: drop it and refill.
          err_d   = 1'b1;
          wcnt_d  = '0;
          ecnt_d  = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      ecnt_q      <= '0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ecnt_q      <= ecnt_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  assign accept = ready && bus.in_valid;
  assign is_a   = (wcnt_q < WCNT_W'(WPS));
  assign wr_idx = is_a ? IDX_W'(wcnt_q) : IDX_W'(wcnt_q - WCNT_W'(WPS));

  operand_shreg u_seg_a (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept && is_a),
    .wr_idx   (wr_idx),
    .wr_data  (bus.in_data),
    .shift_en (shift),
    .head     (a_head)
  );

  operand_shreg u_seg_b (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept && !is_a),
    .wr_idx   (wr_idx),
    .wr_data  (bus.in_data),
    .shift_en (shift),
    .head     (b_head)
  );

  assign bus.in_ready = ready;
  assign bus.op_valid = op_valid;
  assign bus.a_out    = op_valid ? a_head : '0;
  assign bus.b_out    = op_valid ? b_head : '0;
  assign load_done    = load_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - scoreboard bench for operand_loader
module tb_operand_loader;

  logic clk = 1'b0;
  logic rst;
  logic load_en, alu_en, load_done, err;

  operand_loader_if bus ();

  operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .alu_en    (alu_en),
    .bus       (bus.slave),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  logic [15:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (load_done) done_cnt++;
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (bus.op_valid) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("pair", {16'h0, bus.a_out, bus.b_out}, {16'h0, sb.pop_front()});
      end else begin
        check("zero_when_invalid", {24'h0, bus.a_out | bus.b_out}, 32'h0);
      end
    end
  end

  // mode: 0 plain, 1 in_valid toggling, 2 five-cycle load_en gap, 3 one-cycle alu_en gap
  task automatic do_load(input logic [127:0] words, input int mode);
    int  t;
    bit  acc, vphase, gap_done;
    int  acc0, done0;
    acc0 = acc_cnt;
    done0 = done_cnt;
    for (int e = 0; e < 8; e++) sb.push_back({words[8*e +: 8], words[64 + 8*e +: 8]});
    vphase = 1'b1;
    gap_done = 1'b0;
    load_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = words[32*i +: 32];
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        if ((mode >= 2) && (i == 2) && !gap_done) begin
          load_en = 1'b0;
          alu_en = (mode == 3);
          bus.in_valid = 1'b1;
          for (int g = 0; g < ((mode == 2) ? 5 : 1); g++) begin
            @(negedge clk);
            check("ready_low_in_gap", {31'h0, bus.in_ready}, 32'h0);
            @(posedge clk); #1;
          end
          alu_en = 1'b0;
          load_en = 1'b1;
          gap_done = 1'b1;
          if (mode == 3) check("err_alu_in_fill", {31'h0, err}, 32'h1);
        end
        bus.in_valid = (mode == 1) ? vphase : 1'b1;
        vphase = ~vphase;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        t++;
        if (!acc && t > 20) begin
          check("accept_timeout", 32'h0, 32'h1);
          acc = 1'b1;
        end
      end
    end
    load_en = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("load_done_pulse", {31'h0, load_done}, 32'h1);
    @(posedge clk); #1;
    check("accept_count", acc_cnt - acc0, 32'd4);
    check("done_count", done_cnt - done0, 32'd1);
  endtask

  task automatic drain(input int stall_at);
    int n;
    n = (stall_at >= 0) ? 10 : 9;
    for (int c = 0; c < n; c++) begin
      alu_en = (c != stall_at);
      @(negedge clk);
      if (c == n - 1) check("trailing_alu_en", {31'h0, bus.op_valid}, 32'h0);
      if (c == 0) check("load_done_single", {31'h0, load_done}, 32'h0);
      @(posedge clk); #1;
    end
    alu_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] w;
    rst = 1'b1;
    load_en = 1'b0;
    alu_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    @(negedge clk);
    check("rst_outputs", {26'h0, bus.in_ready, bus.op_valid, load_done, err, 2'b00},
          32'h0);
    check("rst_ab", {16'h0, bus.a_out, bus.b_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic load and drain
    do_load(128'h18171615_14131211_08070605_04030201, 0);
    drain(-1);
    check("err_basic", {31'h0, err}, 32'h0);

    // back-pressure
    do_load(128'hA8A7A6A5_A4A3A2A1_58575655_54535251, 1);
    drain(-1);

    // load_en gap, drain with one stall cycle
    do_load(128'hF0E0D0C0_B0A09080_70605040_30201000, 2);
    drain(4);
    check("err_after_gap", {31'h0, err}, 32'h0);

    // reset mid-drain after three elements
    do_load(128'h3F3E3D3C_3B3A3938_2F2E2D2C_2B2A2928, 0);
    alu_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_mid_outputs", {27'h0, bus.in_ready, bus.op_valid, load_done, err, 1'b0},
          32'h0);
    check("rst_mid_ab", {16'h0, bus.a_out, bus.b_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    alu_en = 1'b0;
    do_load(128'h88776655_44332211_0F0E0D0C_0B0A0908, 0);
    drain(-1);
    check("err_before_full_err", {31'h0, err}, 32'h0);

    // load_en while FULL discards and refills from word 0
    do_load(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 0);
    load_en = 1'b1;
    @(posedge clk); #1;
    check("err_load_in_full", {31'h0, err}, 32'h1);
    sb.delete();
    do_load(128'h47464544_43424140_37363534_33323130, 0);
    drain(-1);

    // alu_en during FILL; err stays sticky
    do_load(128'h67666564_63626160_57565554_53525150, 3);
    drain(-1);
    check("err_sticky", {31'h0, err}, 32'h1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("err_cleared", {31'h0, err}, 32'h0);

    // 112 back-to-back random loads
    done_cnt = 0;
    for (int n = 0; n < 112; n++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      do_load(w, 0);
      drain(-1);
    end
    check("random_done_total", done_cnt, 32'd112);
    check("random_err", {31'h0, err}, 32'h0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
